// File: rtl/buffer_mac_reader_if.sv
// Operand-buffer read ports plus the start/result handshake of the MAC reader.
// The slave modport is the reader; the master modport is the buffer and upstream/downstream side.
interface buffer_mac_reader_if #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned AccWidth    = 2 * DataWidth + BufferWidth + 1
);
  logic                   start;
  logic [BufferWidth-1:0] base1;
  logic [BufferWidth-1:0] base2;
  logic [BufferWidth:0]   count;
  logic [BufferWidth-1:0] R_Addr1;
  logic [BufferWidth-1:0] R_Addr2;
  logic [DataWidth-1:0]   DataOut1;
  logic [DataWidth-1:0]   DataOut2;
  logic                   busy;
  logic [AccWidth-1:0]    result;
  logic                   valid;

  modport master (
    output start, base1, base2, count, DataOut1, DataOut2,
    input  R_Addr1, R_Addr2, busy, result, valid
  );

  modport slave (
    input  start, base1, base2, count, DataOut1, DataOut2,
    output R_Addr1, R_Addr2, busy, result, valid
  );
endinterface

// File: rtl/buffer_mac_reader.sv
// Walks two read address streams through the operand buffer and accumulates the products of the
// returned word pairs into a dot product, announced with a one-cycle valid pulse.
module buffer_mac_reader #(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned BufferSize  = 4,
  parameter int unsigned BufferWidth = 2,
  parameter int unsigned AccWidth    = 2 * DataWidth + BufferWidth + 1
) (
  input logic                clk,
  input logic                reset,
  buffer_mac_reader_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e                 state_q;
  logic [BufferWidth-1:0] addr1_q;
  logic [BufferWidth-1:0] addr2_q;
  logic [BufferWidth:0]   remaining_q;
  logic [AccWidth-1:0]    acc_q;
  logic [AccWidth-1:0]    result_q;
  logic                   busy_q;
  logic                   valid_q;

  logic [2*DataWidth-1:0] product;
  logic [AccWidth-1:0]    acc_sum;

  assign product = (2 * DataWidth)'(bus.DataOut1) * (2 * DataWidth)'(bus.DataOut2);
  assign acc_sum = acc_q + AccWidth'(product);

  // Explicit wrap so non-power-of-two buffer sizes step BufferSize-1 -> 0.
  function automatic logic [BufferWidth-1:0] next_addr(input logic [BufferWidth-1:0] a);
    if (a == BufferWidth'(BufferSize - 1)) begin
      return '0;
    end
    return a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr1_q     <= '0;
      addr2_q     <= '0;
      remaining_q <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (bus.start) begin
            if (bus.count != '0) begin
              addr1_q     <= bus.base1;
              addr2_q     <= bus.base2;
              acc_q       <= '0;
              remaining_q <= bus.count;
              busy_q      <= 1'b1;
              state_q     <= StRun;
            end else begin
              result_q <= '0;
              valid_q  <= 1'b1;
            end
          end
        end
        StRun: begin
          acc_q       <= acc_sum;
          addr1_q     <= next_addr(addr1_q);
          addr2_q     <= next_addr(addr2_q);
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == (BufferWidth + 1)'(1)) begin
            result_q <= acc_sum;
            valid_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.R_Addr1 = addr1_q;
  assign bus.R_Addr2 = addr2_q;
  assign bus.busy    = busy_q;
  assign bus.result  = result_q;
  assign bus.valid   = valid_q;

endmodule

// File: tb/tb_buffer_mac_reader.sv
// Directed bench for buffer_mac_reader: stimulus pushes expected results with their valid cycle,
// an independent monitor pops and compares on every valid pulse.
module tb_buffer_mac_reader;
  localparam int unsigned DataWidth   = 8;
  localparam int unsigned BufferSize  = 4;
  localparam int unsigned BufferWidth = 2;
  localparam int unsigned AccWidth    = 19;

  typedef struct {
    int unsigned res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t q[$];
  logic [DataWidth-1:0] mem [BufferSize];

  buffer_mac_reader_if #(
    .DataWidth  (DataWidth),
    .BufferWidth(BufferWidth),
    .AccWidth   (AccWidth)
  ) bus ();

  buffer_mac_reader #(
    .DataWidth  (DataWidth),
    .BufferSize (BufferSize),
    .BufferWidth(BufferWidth),
    .AccWidth   (AccWidth)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  assign bus.DataOut1 = mem[bus.R_Addr1];
  assign bus.DataOut2 = mem[bus.R_Addr2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input int a, input int b, input int c, input int d);
    mem[0] = 8'(a);
    mem[1] = 8'(b);
    mem[2] = 8'(c);
    mem[3] = 8'(d);
  endtask

  // Presents start for one edge; returns #1 after the sampling edge.
  task automatic issue(input int b1, input int b2, input int cnt, input int unsigned exp_res,
                       input bit expect_valid);
    bus.base1 = BufferWidth'(b1);
    bus.base2 = BufferWidth'(b2);
    bus.count = (BufferWidth + 1)'(cnt);
    bus.start = 1'b1;
    if (expect_valid) q.push_back('{res: exp_res, cyc: cyc + 1 + cnt});
    step();
    bus.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && bus.valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got valid with result %0d, expected none (cycle %0d)",
                 bus.result, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", bus.result, e.res);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.base1 = '0;
    bus.base2 = '0;
    bus.count = '0;
    set_mem(3, 5, 7, 2);
    repeat (3) step();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_addr1", bus.R_Addr1, 0);
    check("rst_addr2", bus.R_Addr2, 0);
    reset = 1'b0;
    step();

    // 3*7 + 5*2
    issue(0, 2, 2, 31, 1'b1);
    check("t1_busy", bus.busy, 1);
    check("t1_addr1_a", bus.R_Addr1, 0);
    check("t1_addr2_a", bus.R_Addr2, 2);
    step();
    check("t1_addr1_b", bus.R_Addr1, 1);
    check("t1_addr2_b", bus.R_Addr2, 3);
    step();
    check("t1_busy_end", bus.busy, 0);
    step();

    // Wrapping streams: 7*2 + 2*3 + 3*5
    issue(2, 3, 3, 35, 1'b1);
    step();
    check("t2_addr1_wrap", bus.R_Addr1, 3);
    check("t2_addr2_wrap", bus.R_Addr2, 0);
    step();
    check("t2_addr1_wrap2", bus.R_Addr1, 0);
    check("t2_addr2_wrap2", bus.R_Addr2, 1);
    step();
    repeat (3) step();
    check("t2_result_hold", bus.result, 35);

    // 7 * 255 * 255 needs all 19 bits
    set_mem(255, 255, 255, 255);
    issue(0, 0, 7, 455175, 1'b1);
    for (int i = 0; i < 7; i++) begin
      check("t3_busy_high", bus.busy, 1);
      step();
    end
    check("t3_busy_low", bus.busy, 0);
    step();

    set_mem(3, 5, 7, 2);
    issue(0, 0, 0, 0, 1'b1);
    check("t4_zero_busy", bus.busy, 0);
    step();
    issue(1, 1, 1, 25, 1'b1);
    step();
    step();

    // start during RUN must be dropped, then a back-to-back start in the valid cycle accepted
    issue(0, 2, 2, 31, 1'b1);
    bus.base1 = 2'd2;
    bus.base2 = 2'd3;
    bus.count = 3'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    issue(2, 3, 3, 35, 1'b1);
    repeat (3) step();
    step();

    // Reset in the second RUN cycle discards the run
    issue(0, 0, 4, 0, 1'b0);
    step();
    reset = 1'b1;
    step();
    check("t6_busy", bus.busy, 0);
    check("t6_valid", bus.valid, 0);
    check("t6_result", bus.result, 0);
    check("t6_addr1", bus.R_Addr1, 0);
    check("t6_addr2", bus.R_Addr2, 0);
    reset = 1'b0;
    repeat (8) step();

    for (int i = 0; i < 50 && q.size() != 0; i++) step();
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
